fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. It owns the 32-bit program counter, issues word fetches to instruction memory over a req/ack handshake, and hands each fetched instruction to decode over a valid/ready handshake. Next-PC selection (sequential PC+4 vs. branch redirect) is made by a 32-bit 2:1 mux whose output is registered here as the PC. Branch redirects from later stages squash any instruction in flight.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_bit32_2to1mux.sv | 17 +
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage: default reset PC,
// sequential PC increment, instruction width and the fetch FSM state
// encodings. Also provides a helper that forces an address onto a word
// boundary. No ports; imported by fetch_stage.
package fetch_stage_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // FSM encodings kept as plain constants so they match the legacy
    // encodings used elsewhere in the CPU.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Clears the two byte-offset bits so every fetch is word-aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_bit32_2to1mux.sv
// bit32_2to1mux
// 32-bit two-input multiplexer used for next-PC selection.
// Ports:
//   sel  - 0 selects in1, 1 selects in2
//   in1  - first data input (sequential PC)
//   in2  - second data input (redirect target)
//   out  - selected value
module bit32_2to1mux (
    input  logic        sel,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out
);

    assign out = sel ? in2 : in1;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage. Owns the program counter, issues word fetches
// over a req/ack handshake to instruction memory and hands each fetched
// instruction to decode over a valid/ready handshake. Branch redirects
// from execute squash any fetch that is already in flight.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   branch_taken        - one-cycle redirect strobe
//   branch_target       - redirect address (low two bits ignored)
//   imem_req/imem_addr  - fetch request and its address
//   imem_ack/imem_rdata - memory response and returned instruction word
//   id_valid/id_ready   - decode handshake
//   id_instr/id_pc      - instruction handed to decode and its address
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc
);

    logic [1:0]         state_q,    state_d;
    logic [31:0]        pc_q,       pc_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic               squash_q,   squash_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [31:0]        id_pc_q,    id_pc_d;

    logic [31:0] pc_plus_step;
    logic [31:0] aligned_target;
    logic [31:0] next_pc;

    // Modulo-2^32 add, so the top word wraps to address zero.
    assign pc_plus_step   = pc_q + PC_STEP;
    assign aligned_target = align_word(branch_target);

    bit32_2to1mux u_next_pc_mux (
        .sel (branch_taken),
        .in1 (pc_plus_step),
        .in2 (aligned_target),
        .out (next_pc)
    );

    // Next-state logic. pc tracks where fetching should continue, while
    // req_addr holds the address of the request currently on the bus so a
    // redirect never disturbs an outstanding request.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        squash_d   = squash_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;

        // A redirect always moves pc to the aligned target, whatever state.
        if (branch_taken) begin
            pc_d = next_pc;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (squash_q || branch_taken) begin
                        // Returned word belongs to a stale path; drop it.
                        squash_d = 1'b0;
                    end else begin
                        id_instr_d = imem_rdata;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                        pc_d       = next_pc;
                        state_d    = ST_HOLD;
                    end
                end else if (branch_taken) begin
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // With both strobes high the handshake still completes;
                // decode squashes that instruction itself.
                if (id_ready || branch_taken) begin
                    id_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new request starts whenever we enter FETCH or an ack closes the
        // previous one while staying in FETCH.
        if (state_d == ST_FETCH && (state_q != ST_FETCH || imem_ack)) begin
            req_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            squash_q   <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            squash_q   <= squash_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // Outputs come only from registers or the state decode.
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = req_addr_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed testbench for fetch_stage. Expected fetch addresses and expected
// decode deliveries are queued as stimulus is issued; a monitor on the
// falling clock edge pops and compares them whenever the DUT completes a
// memory or decode handshake. Stimulus changes 1ns after each rising edge.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } dec_item_t;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_fetch[$];
    dec_item_t   exp_dec[$];

    logic [31:0] mon_addr;
    dec_item_t   mon_item;

    fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acknowledge the request currently on the bus with 'data' and let
    // decode take it on the next cycle. Assumes id_ready is high.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        dec_item_t item;
        check32("fetch_req_up", {31'd0, imem_req}, 32'd1);
        item.instr = data;
        item.pc    = addr;
        exp_fetch.push_back(addr);
        exp_dec.push_back(item);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        check32("hold_valid", {31'd0, id_valid}, 32'd1);
        step();
    endtask

    // Monitor: compare every completed handshake against the queues.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            if (exp_fetch.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_fetch: got addr 0x%08h expected none", imem_addr);
            end else begin
                mon_addr = exp_fetch.pop_front();
                check32("fetch_addr", imem_addr, mon_addr);
            end
        end
        if (rst_n && id_valid && id_ready) begin
            if (exp_dec.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_decode: got instr 0x%08h pc 0x%08h expected none",
                         id_instr, id_pc);
            end else begin
                mon_item = exp_dec.pop_front();
                check32("dec_instr", id_instr, mon_item.instr);
                check32("dec_pc", id_pc, mon_item.pc);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        id_ready      = 1'b1;

        // Reset state
        step();
        step();
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_valid", {31'd0, id_valid}, 32'd0);
        check32("rst_instr", id_instr, 32'd0);
        check32("rst_pc", id_pc, 32'd0);

        // First fetch: one IDLE cycle, then request at RESET_PC
        rst_n = 1'b1;
        check32("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        check32("first_req", {31'd0, imem_req}, 32'd1);
        check32("first_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h2002_0001);
        check32("seq_addr", imem_addr, 32'h4);

        // Backpressure: five cycles of id_ready low
        id_ready = 1'b0;
        exp_fetch.push_back(32'h4);
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA_0004;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check32("bp_valid", {31'd0, id_valid}, 32'd1);
            check32("bp_req", {31'd0, imem_req}, 32'd0);
            check32("bp_instr", id_instr, 32'hAAAA_0004);
            check32("bp_pc", id_pc, 32'h4);
            step();
        end
        id_ready = 1'b1;
        exp_dec.push_back('{instr: 32'hAAAA_0004, pc: 32'h4});
        step();
        check32("bp_next_req", {31'd0, imem_req}, 32'd1);
        check32("bp_next_addr", imem_addr, 32'h8);

        // Redirect while a request is outstanding
        do_fetch(32'h8, 32'h0000_0008);
        do_fetch(32'hC, 32'h0000_000C);
        check32("pre_redir_addr", imem_addr, 32'h10);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check32("squash_addr_hold", imem_addr, 32'h10);
            check32("squash_no_valid", {31'd0, id_valid}, 32'd0);
            step();
        end
        exp_fetch.push_back(32'h10);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check32("dropped_valid", {31'd0, id_valid}, 32'd0);
        check32("redir_addr", imem_addr, 32'h100);
        check32("redir_req", {31'd0, imem_req}, 32'd1);

        // Redirect in HOLD together with id_ready
        exp_fetch.push_back(32'h100);
        exp_dec.push_back('{instr: 32'h1111_0100, pc: 32'h100});
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_0100;
        step();
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        step();
        branch_taken = 1'b0;
        check32("hold_redir_valid", {31'd0, id_valid}, 32'd0);
        check32("hold_redir_addr", imem_addr, 32'h200);

        // Redirect in the same cycle as an ack: data dropped
        exp_fetch.push_back(32'h200);
        imem_ack      = 1'b1;
        imem_rdata    = 32'h2222_0200;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        step();
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        check32("ack_redir_valid", {31'd0, id_valid}, 32'd0);
        check32("ack_redir_addr", imem_addr, 32'h300);

        // Two redirects while squashing: last wins, one ack dropped, then wrap
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0500;
        step();
        branch_target = 32'hFFFF_FFFE;
        step();
        branch_taken = 1'b0;
        exp_fetch.push_back(32'h300);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check32("last_target_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 32'h1234_5678);
        check32("wrap_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h0BAD_F00D);
        check32("pre_reset_addr", imem_addr, 32'h4);

        // Asynchronous reset between edges while in FETCH
        #2;
        rst_n = 1'b0;
        #1;
        check32("async_req", {31'd0, imem_req}, 32'd0);
        check32("async_valid", {31'd0, id_valid}, 32'd0);
        check32("async_addr", imem_addr, 32'h0);
        check32("async_instr", id_instr, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check32("rerun_req", {31'd0, imem_req}, 32'd1);
        check32("rerun_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h5555_0000);
        check32("rerun_next_addr", imem_addr, 32'h4);

        step();
        step();
        check32("fetch_queue_empty", exp_fetch.size(), 32'd0);
        check32("dec_queue_empty", exp_dec.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
